bldc_commutator: RTL and testbench

- Six-step hall-sensor commutation stage; sits directly upstream of the three per-phase PWM phase drivers.
- Converts raw hall sensor inputs, a direction bit and a duty magnitude into a per-phase duty_cycle and high_z for phases A, B and C.
- Adds hall synchronisation and filtering, direction-reversal dead time, invalid-hall and illegal-transition detection, and stall detection, with fault latching.

---
 rtl/bldc_commutator.sv | 253 +++++++++++++++++++++++++
 tb/tb_bldc_commutator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_commutator.sv
// Six-step hall commutation stage: synchronises and filters the hall
// sensors, maps the filtered code to per-phase duty/float requests, and
// guards the bridge with direction dead time, hall and stall faults.
module bldc_commutator #(
    parameter int DUTY_WIDTH   = 10,
    parameter int HALL_FILTER  = 4,
    parameter int DIR_DEADTIME = 1024,
    parameter int STALL_CYCLES = 1048576
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  direction,
    input  logic [DUTY_WIDTH-1:0] duty_mag,
    input  logic [2:0]            hall,
    input  logic                  fault_clear,
    output logic [DUTY_WIDTH-1:0] duty_a,
    output logic [DUTY_WIDTH-1:0] duty_b,
    output logic [DUTY_WIDTH-1:0] duty_c,
    output logic                  high_z_a,
    output logic                  high_z_b,
    output logic                  high_z_c,
    output logic                  hall_fault,
    output logic                  stall_fault,
    output logic [15:0]           hall_count,
    output logic                  running
);
    localparam int FW = $clog2(HALL_FILTER + 1);
    localparam int DW = $clog2(DIR_DEADTIME + 1);
    localparam int SW = $clog2(STALL_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX   = FW'(HALL_FILTER);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DIR_DEADTIME - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);
    localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD, S_FAULT} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_hall_s1, r_hall_s2, r_hall_cand, r_hall_filt, r_hall_prev;
    logic [FW-1:0]         r_filt_cnt, w_filt_cnt_next;
    logic [DW-1:0]         r_dead_cnt;
    logic [SW-1:0]         r_stall_cnt;
    logic [15:0]           r_hall_count;
    logic                  r_dir, r_hall_fault, r_stall_fault;
    logic                  w_hall_fault_set, w_stall_fault_set, w_fault_clear;
    logic [2:0]            w_pos_new, w_pos_old;
    logic                  w_hall_valid, w_prev_valid, w_hall_changed;
    logic                  w_step_fwd, w_step_rev, w_hall_bad, w_stall_hit, w_drive;
    logic [2:0]            w_pwm_fwd, w_low_fwd, w_pwm_sel, w_low_sel;
    logic [DUTY_WIDTH-1:0] r_duty [3];
    logic                  r_high_z [3];

    // Position of a hall code along the forward sequence; 7 marks 000/111.
    function automatic logic [2:0] hall_pos(input logic [2:0] code);
        case (code)
            3'b001:  hall_pos = 3'd0;
            3'b011:  hall_pos = 3'd1;
            3'b010:  hall_pos = 3'd2;
            3'b110:  hall_pos = 3'd3;
            3'b100:  hall_pos = 3'd4;
            3'b101:  hall_pos = 3'd5;
            default: hall_pos = 3'd7;
        endcase
    endfunction

    assign w_pos_new      = hall_pos(r_hall_filt);
    assign w_pos_old      = hall_pos(r_hall_prev);
    assign w_hall_valid   = (w_pos_new != 3'd7);
    assign w_prev_valid   = (w_pos_old != 3'd7);
    assign w_hall_changed = (r_hall_filt != r_hall_prev);
    assign w_step_fwd     = (w_pos_old == 3'd5) ? (w_pos_new == 3'd0) : (w_pos_new == w_pos_old + 3'd1);
    assign w_step_rev     = (w_pos_new == 3'd5) ? (w_pos_old == 3'd0) : (w_pos_old == w_pos_new + 3'd1);
    assign w_hall_bad     = !w_hall_valid ||
                            (w_hall_changed && !(w_prev_valid && (w_step_fwd || w_step_rev)));
    assign w_stall_hit    = (r_state == S_RUN) && (duty_mag != '0) && !w_hall_changed &&
                            (r_stall_cnt >= STALL_LAST);

    // Run length of the current synchronised code, saturating at the filter depth.
    always_comb begin
        w_filt_cnt_next = FW'(1);
        if (r_hall_s2 == r_hall_cand)
            w_filt_cnt_next = (r_filt_cnt == FILT_MAX) ? r_filt_cnt : r_filt_cnt + 1'b1;
    end

    // Two-flop synchroniser, consecutive-sample filter and previous filtered code.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hall_s1   <= '0;
            r_hall_s2   <= '0;
            r_hall_cand <= '0;
            r_hall_filt <= '0;
            r_hall_prev <= '0;
            r_filt_cnt  <= '0;
        end else begin
            r_hall_s1   <= hall;
            r_hall_s2   <= r_hall_s1;
            r_hall_prev <= r_hall_filt;
            r_filt_cnt  <= w_filt_cnt_next;
            if (r_hall_s2 != r_hall_cand)
                r_hall_cand <= r_hall_s2;
            if (w_filt_cnt_next == FILT_MAX)
                r_hall_filt <= r_hall_s2;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next state and fault set/clear; faults outrank enable and direction changes.
    always_comb begin
        w_state_next      = r_state;
        w_hall_fault_set  = 1'b0;
        w_stall_fault_set = 1'b0;
        w_fault_clear     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && w_hall_valid)
                    w_state_next = S_RUN;
            end
            S_RUN: begin
                w_hall_fault_set  = w_hall_bad;
                w_stall_fault_set = w_stall_hit;
                if (w_hall_bad || w_stall_hit)
                    w_state_next = S_FAULT;
                else if (!enable)
                    w_state_next = S_IDLE;
                else if (direction != r_dir)
                    w_state_next = S_DEAD;
            end
            S_DEAD: begin
                w_hall_fault_set = w_hall_bad;
                if (w_hall_bad)
                    w_state_next = S_FAULT;
                else if (!enable)
                    w_state_next = S_IDLE;
                else if ((direction == r_dir) && (r_dead_cnt == DEAD_LAST))
                    w_state_next = S_RUN;
            end
            default: begin
                // A still-invalid code is a live fault, so a clear request cannot win.
                if (fault_clear) begin
                    if (!w_hall_valid)
                        w_hall_fault_set = 1'b1;
                    else begin
                        w_fault_clear = 1'b1;
                        w_state_next  = S_IDLE;
                    end
                end
            end
        endcase
    end

    // Dead-time counter, direction latch, stall counter and hall edge counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dead_cnt   <= '0;
            r_dir        <= 1'b0;
            r_stall_cnt  <= '0;
            r_hall_count <= '0;
        end else begin
            if ((r_state == S_DEAD) && (w_state_next == S_DEAD) && (direction == r_dir))
                r_dead_cnt <= r_dead_cnt + 1'b1;
            else
                r_dead_cnt <= '0;
            if ((w_state_next == S_DEAD) || ((w_state_next == S_RUN) && (r_state != S_RUN)))
                r_dir <= direction;
            if ((r_state == S_RUN) && (w_state_next == S_RUN) && !w_hall_changed && (duty_mag != '0)) begin
                if (r_stall_cnt != STALL_MAX)
                    r_stall_cnt <= r_stall_cnt + 1'b1;
            end else begin
                r_stall_cnt <= '0;
            end
            if ((r_state == S_RUN) && w_hall_changed)
                r_hall_count <= r_hall_count + 16'd1;
        end
    end

    // Latched fault flags; a set in the same cycle as a clear keeps the flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hall_fault  <= 1'b0;
            r_stall_fault <= 1'b0;
        end else begin
            if (w_hall_fault_set)
                r_hall_fault <= 1'b1;
            else if (w_fault_clear)
                r_hall_fault <= 1'b0;
            if (w_stall_fault_set)
                r_stall_fault <= 1'b1;
            else if (w_fault_clear)
                r_stall_fault <= 1'b0;
        end
    end

    // Forward commutation table as one-hot phase masks, bit 0 = A.
    always_comb begin
        w_pwm_fwd = 3'b000;
        w_low_fwd = 3'b000;
        case (r_hall_filt)
            3'b001: begin w_pwm_fwd = 3'b001; w_low_fwd = 3'b010; end
            3'b011: begin w_pwm_fwd = 3'b001; w_low_fwd = 3'b100; end
            3'b010: begin w_pwm_fwd = 3'b010; w_low_fwd = 3'b100; end
            3'b110: begin w_pwm_fwd = 3'b010; w_low_fwd = 3'b001; end
            3'b100: begin w_pwm_fwd = 3'b100; w_low_fwd = 3'b001; end
            3'b101: begin w_pwm_fwd = 3'b100; w_low_fwd = 3'b010; end
            default: begin w_pwm_fwd = 3'b000; w_low_fwd = 3'b000; end
        endcase
    end

    // Whenever the next state is RUN the live direction input equals the latched one.
    assign w_pwm_sel = direction ? w_low_fwd : w_pwm_fwd;
    assign w_low_sel = direction ? w_pwm_fwd : w_low_fwd;
    assign w_drive   = (w_state_next == S_RUN);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_phase
            // Per-phase registered duty and float request.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_duty[gi]   <= '0;
                    r_high_z[gi] <= 1'b1;
                end else if (w_drive && w_pwm_sel[gi]) begin
                    r_duty[gi]   <= duty_mag;
                    r_high_z[gi] <= 1'b0;
                end else if (w_drive && w_low_sel[gi]) begin
                    r_duty[gi]   <= '0;
                    r_high_z[gi] <= 1'b0;
                end else begin
                    r_duty[gi]   <= '0;
                    r_high_z[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign duty_a      = r_duty[0];
    assign duty_b      = r_duty[1];
    assign duty_c      = r_duty[2];
    assign high_z_a    = r_high_z[0];
    assign high_z_b    = r_high_z[1];
    assign high_z_c    = r_high_z[2];
    assign hall_fault  = r_hall_fault;
    assign stall_fault = r_stall_fault;
    assign hall_count  = r_hall_count;
    assign running     = (r_state == S_RUN);
endmodule

// File: tb/tb_bldc_commutator.sv
// Self-checking bench for bldc_commutator: table vectors, hand sequences
// for glitch, dead time, faults, stall, wrap and async reset, then a
// randomized legal hall walk against a behavioural model.
module tb_bldc_commutator;
    localparam int DW = 10;
    localparam int HF = 4;
    localparam int DD = 16;
    localparam int SC = 100;
    localparam logic [63:0] ALLZ = 64'h7;

    logic          clock;
    logic          reset, enable, direction, fault_clear;
    logic [DW-1:0] duty_mag;
    logic [2:0]    hall;
    logic [DW-1:0] duty_a, duty_b, duty_c;
    logic          high_z_a, high_z_b, high_z_c;
    logic          hall_fault, stall_fault, running;
    logic [15:0]   hall_count;

    int checks = 0;
    int errors = 0;

    bldc_commutator #(
        .DUTY_WIDTH(DW), .HALL_FILTER(HF), .DIR_DEADTIME(DD), .STALL_CYCLES(SC)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .direction(direction),
        .duty_mag(duty_mag), .hall(hall), .fault_clear(fault_clear),
        .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
        .high_z_a(high_z_a), .high_z_b(high_z_b), .high_z_c(high_z_c),
        .hall_fault(hall_fault), .stall_fault(stall_fault),
        .hall_count(hall_count), .running(running)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural model: position along the forward sequence -> phases (0=A,1=B,2=C).
    int         PWM_PH [6] = '{0, 0, 1, 1, 2, 2};
    int         LOW_PH [6] = '{1, 2, 2, 0, 0, 1};
    logic [2:0] CODE   [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    function automatic logic [63:0] model(input int idx, input logic dir,
                                          input logic [DW-1:0] duty, input bit active);
        logic [DW-1:0] d [3];
        logic          z [3];
        int            p, l;
        if (!active) return ALLZ;
        p = dir ? LOW_PH[idx] : PWM_PH[idx];
        l = dir ? PWM_PH[idx] : LOW_PH[idx];
        for (int ph = 0; ph < 3; ph++) begin
            d[ph] = (ph == p) ? duty : '0;
            z[ph] = (ph != p) && (ph != l);
        end
        return {31'b0, d[0], d[1], d[2], z[0], z[1], z[2]};
    endfunction

    function automatic logic [63:0] outs();
        return {31'b0, duty_a, duty_b, duty_c, high_z_a, high_z_b, high_z_c};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_pulse();
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
    endtask

    typedef struct {
        logic [2:0]    hall;
        logic          dir;
        logic [DW-1:0] duty;
        logic [DW-1:0] da, db, dc;
        logic [2:0]    hz;      // {a,b,c}
        logic [15:0]   cnt;
    } vec_t;

    vec_t vecs [13];

    int          idx;
    logic        dir_m;
    logic [15:0] exp_cnt;
    int          first;
    int          step;
    bit          flip;
    logic [DW-1:0] dm;

    initial begin
        vecs[0]  = '{3'b011, 1'b0, 10'd300,  10'd300,  10'd0,    10'd0,    3'b010, 16'd1};
        vecs[1]  = '{3'b010, 1'b0, 10'd511,  10'd0,    10'd511,  10'd0,    3'b100, 16'd2};
        vecs[2]  = '{3'b110, 1'b0, 10'd1023, 10'd0,    10'd1023, 10'd0,    3'b001, 16'd3};
        vecs[3]  = '{3'b100, 1'b0, 10'd1,    10'd0,    10'd0,    10'd1,    3'b010, 16'd4};
        vecs[4]  = '{3'b101, 1'b0, 10'd77,   10'd0,    10'd0,    10'd77,   3'b100, 16'd5};
        vecs[5]  = '{3'b001, 1'b0, 10'd300,  10'd300,  10'd0,    10'd0,    3'b001, 16'd6};
        vecs[6]  = '{3'b001, 1'b1, 10'd300,  10'd0,    10'd300,  10'd0,    3'b001, 16'd6};
        vecs[7]  = '{3'b011, 1'b1, 10'd200,  10'd0,    10'd0,    10'd200,  3'b010, 16'd7};
        vecs[8]  = '{3'b010, 1'b1, 10'd400,  10'd0,    10'd0,    10'd400,  3'b100, 16'd8};
        vecs[9]  = '{3'b110, 1'b1, 10'd600,  10'd600,  10'd0,    10'd0,    3'b001, 16'd9};
        vecs[10] = '{3'b100, 1'b1, 10'd800,  10'd800,  10'd0,    10'd0,    3'b010, 16'd10};
        vecs[11] = '{3'b101, 1'b1, 10'd1000, 10'd0,    10'd1000, 10'd0,    3'b100, 16'd11};
        vecs[12] = '{3'b001, 1'b1, 10'd5,    10'd0,    10'd5,    10'd0,    3'b001, 16'd12};

        reset = 1'b1; enable = 1'b0; direction = 1'b0; duty_mag = 10'd300;
        hall = 3'b001; fault_clear = 1'b0;
        tick(2);
        check("reset_outs", outs(), ALLZ);
        check("reset_flags", 64'({hall_fault, stall_fault, running}), 64'd0);
        check("reset_count", 64'(hall_count), 64'd0);

        // First commutation step from IDLE.
        reset = 1'b0; enable = 1'b1;
        tick(8);
        check("start_outs", outs(), model(0, 1'b0, 10'd300, 1'b1));
        check("start_run", 64'(running), 64'd1);
        check("start_count", 64'(hall_count), 64'd0);

        // Table vectors: forward then reverse full rotations.
        for (int i = 0; i < 13; i++) begin
            hall = vecs[i].hall; direction = vecs[i].dir; duty_mag = vecs[i].duty;
            tick(20);
            check("tbl_outs", outs(), {31'b0, vecs[i].da, vecs[i].db, vecs[i].dc, vecs[i].hz});
            check("tbl_count", 64'(hall_count), 64'(vecs[i].cnt));
            $display("vec %0d hall=%b dir=%0d duty=%0d count=%0d", i, vecs[i].hall,
                     vecs[i].dir, vecs[i].duty, hall_count);
        end

        // 3-cycle glitch shorter than the filter depth.
        hall = 3'b011;
        tick(3);
        hall = 3'b001;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_outs", outs(), model(0, 1'b1, 10'd5, 1'b1));
        end
        check("glitch_count", 64'(hall_count), 64'd12);

        // Direction reversal: exactly DD cycles floating, then reversed table.
        direction = 1'b0;
        for (int i = 1; i <= DD + 1; i++) begin
            tick(1);
            check("dead_outs", outs(), (i <= DD) ? ALLZ : model(0, 1'b0, 10'd5, 1'b1));
        end
        // A second toggle mid dead time restarts the count.
        direction = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check("dead_first", outs(), ALLZ);
        end
        direction = 1'b0;
        for (int i = 1; i <= DD + 1; i++) begin
            tick(1);
            check("dead_restart", outs(), (i <= DD) ? ALLZ : model(0, 1'b0, 10'd5, 1'b1));
        end

        // Non-adjacent jump 001 -> 010.
        hall = 3'b010;
        tick(10);
        check("adj_fault", 64'(hall_fault), 64'd1);
        check("adj_outs", outs(), ALLZ);
        check("adj_run", 64'(running), 64'd0);
        clear_pulse();
        check("adj_clear", 64'({hall_fault, running}), 64'd0);
        tick(1);
        check("adj_rerun", outs(), model(2, 1'b0, 10'd5, 1'b1));
        check("adj_running", 64'(running), 64'd1);

        // Invalid code 111; a clear while it is present keeps the flag.
        hall = 3'b011; tick(10);
        hall = 3'b001; tick(10);
        check("back_001", outs(), model(0, 1'b0, 10'd5, 1'b1));
        hall = 3'b111; tick(10);
        check("inv_fault", 64'(hall_fault), 64'd1);
        check("inv_outs", outs(), ALLZ);
        clear_pulse();
        check("inv_keep", 64'({hall_fault, running}), 64'b10);
        hall = 3'b001; tick(10);
        check("inv_still", 64'(hall_fault), 64'd1);
        clear_pulse();
        check("inv_clear", 64'(hall_fault), 64'd0);
        tick(1);
        check("inv_rerun", 64'(running), 64'd1);

        // Zero duty: low-side brake, never stalls.
        duty_mag = 10'd0;
        tick(500);
        check("brake_nostall", 64'(stall_fault), 64'd0);
        check("brake_outs", outs(), model(0, 1'b0, 10'd0, 1'b1));

        // Frozen hall with nonzero duty: stall fault on the 100th cycle.
        duty_mag = 10'd50;
        first = 0;
        for (int i = 1; i <= 150 && first == 0; i++) begin
            tick(1);
            if (stall_fault) first = i;
        end
        check("stall_at", 64'(first), 64'(SC));
        check("stall_outs", outs(), ALLZ);
        check("stall_hallflag", 64'(hall_fault), 64'd0);
        clear_pulse();
        check("stall_clear", 64'(stall_fault), 64'd0);
        tick(1);
        check("stall_rerun", 64'(running), 64'd1);

        // hall_count wrap, starting from a forced 0xFFFF.
        force dut.r_hall_count = 16'hFFFF;
        #1;
        release dut.r_hall_count;
        hall = 3'b011;
        tick(10);
        check("wrap_count", 64'(hall_count), 64'd0);
        check("wrap_outs", outs(), model(1, 1'b0, 10'd50, 1'b1));

        // Random legal walk against the model.
        idx = 1; dir_m = 1'b0; exp_cnt = 16'd0;
        for (int t = 0; t < 40; t++) begin
            step  = ($urandom_range(0, 1) == 1) ? 1 : 5;
            idx   = (idx + step) % 6;
            flip  = ($urandom_range(0, 4) == 0);
            dir_m = dir_m ^ flip;
            dm    = 10'($urandom_range(0, 1023));
            hall = CODE[idx]; direction = dir_m; duty_mag = dm;
            tick(26 + int'($urandom_range(0, 3)));
            if (!flip) exp_cnt = exp_cnt + 16'd1;
            check("rnd_outs", outs(), model(idx, dir_m, dm, 1'b1));
            check("rnd_count", 64'(hall_count), 64'(exp_cnt));
            check("rnd_state", 64'({running, hall_fault, stall_fault}), 64'b100);
            $display("txn %0d hall=%b dir=%0d duty=%0d count=%0d", t, CODE[idx], dir_m, dm, hall_count);
        end

        // Asynchronous reset between clock edges.
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_outs", outs(), ALLZ);
        check("async_flags", 64'({running, hall_fault, stall_fault}), 64'd0);
        check("async_count", 64'(hall_count), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        tick(3);
        check("async_filter", 64'(running), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
